// File: rtl/even_parity_serializer_pkg.sv
// Shared types and constants for the even-parity serializer and its parity helpers.
package even_parity_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DefaultDataW = 8;

endpackage

// File: rtl/even_parity_serializer_accum.sv
// 1-bit sequential XOR accumulator; clr has priority over en.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= 1'b0;
    end else if (en) begin
      q_q <= q_q ^ d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/even_parity_serializer.sv
// Accepts a parallel word, shifts it out LSB-first and appends a parity beat as the frame's last
// beat.
module even_parity_serializer
  import even_parity_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ODD    = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_out,
  output logic              ser_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned     BitW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);
  localparam logic            ParInv  = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              acc_clr, acc_en, acc_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    frame_cnt_d = frame_cnt_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    in_ready    = 1'b0;
    ser_valid   = 1'b0;
    ser_out     = 1'b0;
    ser_last    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d  = in_data;
          bitcnt_d = '0;
          acc_clr  = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        ser_valid = 1'b1;
        ser_out   = shreg_q[0];
        if (ser_ready) begin
          acc_en   = 1'b1;
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LastBit) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        ser_valid = 1'b1;
        ser_out   = acc_q ^ ParInv;
        ser_last  = 1'b1;
        if (ser_ready) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset aborts any frame immediately: no handshake or beat is visible while rst is high.
    if (rst) begin
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      ser_last  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  parity_accum u_parity_accum (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (shreg_q[0]),
    .q   (acc_q)
  );

  assign busy      = (state_q != StIdle) && !rst;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/even_parity_serializer.md
Name: even_parity_serializer

Overview:
Frame controller that sequences a serial even-parity generator. It accepts a parallel word on a valid/ready handshake and shifts it out LSB-first, one bit per accepted beat. It accumulates the running parity and appends it as the final beat of each frame. It sits between a word producer and a serial link or checker. It generalises the 3-input even-parity function to a DATA_W-bit sequential frame.

Parameters:
DATA_W, 8, data word width in bits (legal range 2..32)
ODD, 0, 0 = even parity bit appended, 1 = odd parity bit appended
CNT_W, 16, width of the sent-frame counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  parallel word; sampled only on an in_valid && in_ready cycle
ser_valid  output  1  ser_out carries a valid beat
ser_ready  input  1  consumer accepts the current beat
ser_out  output  1  serial data or parity bit
ser_last  output  1  current beat is the parity bit (end of frame)
busy  output  1  a frame is in progress (state != IDLE)
frame_cnt  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset state while rst is high and on the first cycle after it:
  - state = IDLE; shift register, bit counter, parity accumulator and frame_cnt all = 0.
  - ser_valid = ser_last = ser_out = busy = 0.
  - in_ready = 0 while rst is high.
- FSM states are IDLE, SHIFT and PARITY.
- IDLE:
  - in_ready = 1; ser_valid = 0; ser_out = 0.
  - On in_valid: load shreg <= in_data, bitcnt <= 0, acc <= 0, then go to SHIFT.
- SHIFT:
  - ser_valid = 1; ser_out = shreg[0]; ser_last = 0; in_ready = 0.
  - On ser_ready: acc <= acc ^ shreg[0], shreg >>= 1, bitcnt++.
  - If bitcnt == DATA_W-1 when the beat is accepted, go to PARITY.
- PARITY:
  - ser_valid = 1; ser_out = acc ^ ODD; ser_last = 1.
  - On ser_ready: frame_cnt++ and go to IDLE.
- Backpressure: while ser_ready = 0, ser_out, ser_last and all internal state hold unchanged. There is no limit on stall length.
- Latency: a word accepted at edge N presents its first bit after edge N, and ser_out is combinational from registered state. The frame is DATA_W+1 beats long.
- Throughput: the minimum is DATA_W+2 cycles per word, because IDLE costs one cycle. There is no back-to-back accept from PARITY.
- in_valid asserted while busy is ignored; the producer must hold the word until in_ready.
- in_data is don't-care outside the accept cycle; changes while busy must not affect the frame in flight.
- frame_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-frame: the frame is aborted and no parity beat is emitted. frame_cnt clears, and state returns to IDLE on the next edge.
- Simultaneous rst and handshake: rst wins and the word is not accepted.
- ser_out is 0 whenever ser_valid = 0.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2).
  - PAR_EVEN = 0 and PAR_ODD = 1 constants.
  - Default DATA_W.
- One sub-module, parity_accum: a 1-bit sequential XOR accumulator.
  - Ports: clk, rst, clr, en, d, q.
  - clr has priority over en.
  - Reusable by a future receive-side checker.
- FSM, shift register and counters live in the top module.

Test Plan:
- Reset: assert rst for 3 cycles with in_valid = 1 -> in_ready = 0, ser_valid = 0, frame_cnt = 0, no word accepted. After release, in_ready = 1 on the next cycle.
- Even-parity word, DATA_W = 8, ser_ready tied 1, in_data = 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 then parity 0 with ser_last = 1. frame_cnt = 1 after 10 cycles.
- Odd-weight word, in_data = 8'h07 -> bits 1,1,1,0,0,0,0,0, parity 1. Rerun with ODD = 1 -> parity 0. in_data = 8'h00 -> 8 zeros, parity 0 (ODD = 0).
- Backpressure: 8'hA5 with ser_ready dropped for 4 cycles at bit 3 and for 2 cycles on the parity beat -> ser_out and ser_last hold, the sequence is unchanged, and the frame completes 6 cycles later.
- Busy and handshake: in_data toggles and in_valid stays high during a frame -> in_ready = 0 throughout, the frame in flight is unaffected, and the next word is accepted exactly one cycle after the parity beat is accepted.
- Reset mid-frame and wrap: rst pulse at bit 4 -> ser_valid = 0 and frame_cnt = 0 next cycle, no parity beat. With CNT_W = 2, send 5 frames -> frame_cnt = 1.
